// File: rtl/timer_pkg.sv
// Shared definitions for the prescaled event timer family.
//   US_CLKS_50MHZ : clk cycles per microsecond at 50 MHz
//   FIVE_MIN_US   : five minutes expressed in microseconds
//   timer_state_e : run-control state
//   wrap_add      : modular add for an operand pair already bounded by max / max+1
package timer_pkg;

    localparam int unsigned US_CLKS_50MHZ = 50;
    localparam int unsigned FIVE_MIN_US   = 300000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } timer_state_e;

    // (a + b) mod (max + 1). Callers guarantee a <= max and b <= max + 1, so the
    // sum never exceeds 2*max + 1 and one conditional subtract is enough. The
    // 64-bit operands leave headroom for the extra carry bit of any WIDTH < 64.
    function automatic logic [63:0] wrap_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [63:0] max);
        logic [63:0] sum;
        sum = a + b;
        if (sum > max) begin
            sum = sum - max - 64'd1;
        end
        return sum;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Clock divider producing a one-cycle tick every CLKS_PER_TICK enabled cycles.
//   clk    : clock
//   resetn : asynchronous reset, active high
//   run    : advance the phase counter this cycle
//   clr    : return the phase counter to 0 (wins over run)
//   tick   : high while run is set and the phase counter is at its last value
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = US_CLKS_50MHZ
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_TICK);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] phase_q;

    assign tick = run && (phase_q == LAST);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            phase_q <= '0;
        end else if (clr) begin
            phase_q <= '0;
        end else if (run) begin
            phase_q <= (phase_q == LAST) ? '0 : phase_q + 1'b1;
        end
    end

endmodule

// File: rtl/prescaled_event_timer.sv
// Microsecond timebase with a wrapping tick counter and NUM_CH compare channels.
//   clk, resetn        : clock, asynchronous active-high reset
//   start, stop, clear : run-control pulses (clear > stop > start)
//   cmp_we, cmp_sel    : write strobe and channel index for compare configuration
//   cmp_val, cmp_period: absolute match count and re-arm increment (0 = one-shot)
//   count, running     : current tick count, state == RUN
//   tick, wrap         : prescaler terminal pulse, registered MAX_COUNT -> 0 pulse
//   match, armed       : registered per-channel match pulses, channels pending a match
module prescaled_event_timer
    import timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_TICK = US_CLKS_50MHZ,
    parameter int unsigned WIDTH         = 29,
    parameter int unsigned MAX_COUNT     = FIVE_MIN_US,
    parameter int unsigned NUM_CH        = 4
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        start,
    input  logic                                        stop,
    input  logic                                        clear,
    input  logic                                        cmp_we,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cmp_sel,
    input  logic [WIDTH-1:0]                            cmp_val,
    input  logic [WIDTH-1:0]                            cmp_period,
    output logic [WIDTH-1:0]                            count,
    output logic                                        running,
    output logic                                        tick,
    output logic                                        wrap,
    output logic [NUM_CH-1:0]                           match,
    output logic [NUM_CH-1:0]                           armed
);

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH + 1)'(MAX_COUNT);

    timer_state_e     state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] next_count;
    logic             wrap_q;
    logic             presc_run;
    logic             wr_ok;
    logic [WIDTH:0]   per_ext;
    logic [WIDTH:0]   per_in;

    // Run control: a single FSM register, clear first, then stop, then start.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (start) state_q <= RUN;
                RUN:     if (stop)  state_q <= HOLD;
                HOLD:    if (start) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign running = (state_q == RUN);

    // The stop/clear edge itself does not advance the prescaler, so a paused
    // timer resumes at exactly the phase it was frozen with.
    assign presc_run = running && !stop && !clear;

    tick_prescaler #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_presc (
        .clk   (clk),
        .resetn(resetn),
        .run   (presc_run),
        .clr   (clear),
        .tick  (tick)
    );

    assign next_count = (count_q == MAX_W) ? '0 : count_q + 1'b1;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else if (clear) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q <= tick && (count_q == MAX_W);
            if (tick) begin
                count_q <= next_count;
            end
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

    // Whole write is dropped for an out-of-range channel or compare value.
    assign wr_ok   = cmp_we && (32'(cmp_sel) < NUM_CH) && (cmp_val <= MAX_W);
    // Periods beyond the count range collapse to one full revolution.
    assign per_ext = {1'b0, cmp_period};
    assign per_in  = (per_ext > MAX_EXT) ? MAX_EXT + 1'b1 : per_ext;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cmp_q;
        logic [WIDTH:0]   per_q;
        logic             armed_q;
        logic             match_q;
        logic             we_ch;
        logic             hit;

        assign we_ch = wr_ok && (32'(cmp_sel) == 32'(i));
        // Compare against the value count is about to take, so the match pulse
        // lines up with the first cycle count shows it.
        assign hit   = armed_q && tick && (next_count == cmp_q);

        always_ff @(posedge clk or posedge resetn) begin
            if (resetn) begin
                cmp_q   <= '0;
                per_q   <= '0;
                armed_q <= 1'b0;
                match_q <= 1'b0;
            end else begin
                match_q <= hit;
                if (we_ch) begin
                    // A write overrides any re-arm from a coincident match.
                    cmp_q   <= cmp_val;
                    per_q   <= per_in;
                    armed_q <= 1'b1;
                end else if (clear) begin
                    if (per_q != '0) begin
                        armed_q <= 1'b1;
                    end
                end else if (hit) begin
                    if (per_q == '0) begin
                        armed_q <= 1'b0;
                    end else begin
                        cmp_q <= WIDTH'(wrap_add(64'(cmp_q), 64'(per_q), 64'(MAX_COUNT)));
                    end
                end
            end
        end

        assign match[i] = match_q;
        assign armed[i] = armed_q;
    end

endmodule

// File: tb/tb_prescaled_event_timer.sv
module tb_prescaled_event_timer;

    localparam int unsigned W = 29;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         stop;
    logic         clear;
    logic         cmp_we;
    logic [0:0]   cmp_sel;
    logic [W-1:0] cmp_val;
    logic [W-1:0] cmp_period;
    logic [W-1:0] count;
    logic         running;
    logic         tick;
    logic         wrap;
    logic [1:0]   match;
    logic [1:0]   armed;

    int n_cmp  = 0;
    int n_fail = 0;

    prescaled_event_timer #(
        .CLKS_PER_TICK(4),
        .WIDTH        (W),
        .MAX_COUNT    (9),
        .NUM_CH       (2)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .cmp_we    (cmp_we),
        .cmp_sel   (cmp_sel),
        .cmp_val   (cmp_val),
        .cmp_period(cmp_period),
        .count     (count),
        .running   (running),
        .tick      (tick),
        .wrap      (wrap),
        .match     (match),
        .armed     (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         start;
        logic         stop;
        logic         clear;
        logic         we;
        logic         sel;
        int           val;
        int           per;
        int           nwait;
        int           e_count;
        logic         e_run;
        logic         e_tick;
        logic         e_wrap;
        logic [1:0]   e_match;
        logic [1:0]   e_armed;
    } vec_t;

    function automatic vec_t mk(logic st, logic sp, logic cl, logic we, logic sel,
                                int val, int per, int nwait, int cnt,
                                logic r, logic t, logic w, logic [1:0] m, logic [1:0] a);
        vec_t v;
        v.start = st; v.stop = sp; v.clear = cl; v.we = we; v.sel = sel;
        v.val = val; v.per = per; v.nwait = nwait; v.e_count = cnt;
        v.e_run = r; v.e_tick = t; v.e_wrap = w; v.e_match = m; v.e_armed = a;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input logic r, input logic t,
                             input logic w, input logic [1:0] m, input logic [1:0] a);
        check({tag, ".count"},   64'(count),   64'(c));
        check({tag, ".running"}, 64'(running), 64'(r));
        check({tag, ".tick"},    64'(tick),    64'(t));
        check({tag, ".wrap"},    64'(wrap),    64'(w));
        check({tag, ".match"},   64'(match),   64'(m));
        check({tag, ".armed"},   64'(armed),   64'(a));
    endtask

    task automatic idle_inputs();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        cmp_we = 1'b0; cmp_sel = '0; cmp_val = '0; cmp_period = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        idle_inputs();
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(tag, 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        resetn = 1'b0;
    endtask

    vec_t tv[18];

    initial begin
        // Channel sequence: ch0 one-shot at 5, ch1 periodic 8 step 4, then a
        // rewrite of ch0 landing on the very edge it matches.
        tv[0]  = mk(0,0,0,1,0,5,0, 0,  0,1'b0,0,0,2'b00,2'b01);
        tv[1]  = mk(0,0,0,1,1,8,4, 0,  0,1'b0,0,0,2'b00,2'b11);
        tv[2]  = mk(1,0,0,0,0,0,0, 0,  0,1'b1,0,0,2'b00,2'b11);
        tv[3]  = mk(0,0,0,0,0,0,0, 2,  0,1'b1,1,0,2'b00,2'b11);
        tv[4]  = mk(0,0,0,0,0,0,0, 0,  1,1'b1,0,0,2'b00,2'b11);
        tv[5]  = mk(0,0,0,0,0,0,0,15,  5,1'b1,0,0,2'b01,2'b10);
        tv[6]  = mk(0,0,0,0,0,0,0, 0,  5,1'b1,0,0,2'b00,2'b10);
        tv[7]  = mk(0,0,0,0,0,0,0,10,  8,1'b1,0,0,2'b10,2'b10);
        tv[8]  = mk(0,0,0,0,0,0,0, 7,  0,1'b1,0,1,2'b00,2'b10);
        tv[9]  = mk(0,0,0,0,0,0,0, 0,  0,1'b1,0,0,2'b00,2'b10);
        tv[10] = mk(0,0,0,0,0,0,0, 6,  2,1'b1,0,0,2'b10,2'b10);
        tv[11] = mk(0,0,0,0,0,0,0,11,  5,1'b1,0,0,2'b00,2'b10);
        tv[12] = mk(0,0,0,0,0,0,0, 3,  6,1'b1,0,0,2'b10,2'b10);
        tv[13] = mk(0,0,0,0,0,0,0,15,  0,1'b1,0,1,2'b10,2'b10);
        tv[14] = mk(0,0,0,1,0,5,0, 0,  0,1'b1,0,0,2'b00,2'b11);
        tv[15] = mk(0,0,0,0,0,0,0,17,  4,1'b1,1,0,2'b00,2'b11);
        tv[16] = mk(0,0,0,1,0,9,0, 0,  5,1'b1,0,0,2'b01,2'b11);
        tv[17] = mk(0,0,0,0,0,0,0,15,  9,1'b1,0,0,2'b01,2'b10);

        // Basic count and wrap.
        do_reset("rst0");
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= 44; k++) begin
            if (k > 0) step();
            check_all($sformatf("basic[%0d]", k), (k / 4) % 10, 1'b1, 1'(k % 4 == 3),
                      1'(k == 40), 2'b00, 2'b00);
        end

        // Pause and resume at the same prescaler phase.
        do_reset("rst1");
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (14) step();
        check_all("pause.pre", 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check_all("pause.stop", 3, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("pause.hold_count[%0d]", k), 64'(count), 64'd3);
            check($sformatf("pause.hold_tick[%0d]", k), 64'(tick), 64'd0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        check_all("pause.restart", 3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        step();
        check_all("pause.r1", 3, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        check_all("pause.r2", 4, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

        // clear beats stop and start on the same cycle.
        clear = 1'b1; stop = 1'b1; start = 1'b1;
        step();
        idle_inputs();
        check_all("prio", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        repeat (8) step();
        check_all("prio.idle", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Table-driven compare-channel sequence.
        do_reset("rst2");
        for (int i = 0; i < 18; i++) begin
            start = tv[i].start; stop = tv[i].stop; clear = tv[i].clear;
            cmp_we = tv[i].we; cmp_sel = tv[i].sel;
            cmp_val = W'(tv[i].val); cmp_period = W'(tv[i].per);
            step();
            idle_inputs();
            for (int k = 0; k < tv[i].nwait; k++) step();
            check_all($sformatf("vec[%0d]", i), tv[i].e_count, tv[i].e_run, tv[i].e_tick,
                      tv[i].e_wrap, tv[i].e_match, tv[i].e_armed);
        end

        // Asynchronous reset mid-run, away from any clock edge.
        #2;
        resetn = 1'b1;
        #1;
        check_all("async_rst", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        step();
        check_all("post_rst", 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
